// File: rtl/sp_ram_pkg.sv
// Shared types and elaboration-time parameter checks for the sp_ram_param memory macro.
package sp_ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  function automatic bit read_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit data_w_ok(input int w);
    return (w > 0) && ((w % BYTE_W) == 0);
  endfunction

endpackage

// File: rtl/sp_ram_clear_ctrl.sv
// Clear sequencer: owns the array write port, sweeping INIT_VAL over every word before handing it to user writes.
// state | meaning:  CLEAR | writing INIT_VAL at ptr, ready low;  READY | user traffic accepted
module sp_ram_clear_ctrl
  import sp_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 128,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              user_we,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic [DATA_W-1:0] user_wdata,
  input  logic [BE_W-1:0]   user_be,
  output logic              ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  ram_state_e        state;
  logic [ADDR_W-1:0] ptr;
  logic              clearing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == LAST) begin
            state <= READY;
            ptr   <= '0;
            ready <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        READY: begin
          if (init) begin
            state <= CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign clearing  = (state == CLEAR);
  assign mem_we    = clearing | user_we;
  assign mem_addr  = clearing ? ptr : user_addr;
  assign mem_wdata = clearing ? INIT_VAL : user_wdata;
  assign mem_be    = clearing ? {BE_W{1'b1}} : user_be;

endmodule

// File: rtl/sp_ram_param.sv
// Single-port RAM with byte enables, 1- or 2-cycle read latency and a hardware clear engine.
module sp_ram_param
  import sp_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 128,
  parameter int READ_LAT = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic              init_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              err_o
);

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("sp_ram_param: DATA_W must be a positive multiple of 8");
  end
  if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
    $error("sp_ram_param: READ_LAT must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sp_ram_param: DEPTH must be at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range, accept, user_we, rd_acc, wr_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;

  // Only non-power-of-two depths can see addresses past the end of the array
  assign in_range = ({1'b0, addr_i} < (ADDR_W + 1)'(DEPTH));
  assign accept   = req_i & ready_o;
  assign user_we  = accept & we_i & in_range;
  assign rd_acc   = accept & ~we_i;
  assign wr_err   = accept & we_i & ~in_range;

  sp_ram_clear_ctrl #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT_VAL)
  ) u_clear_ctrl (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .init       (init_i),
    .user_we    (user_we),
    .user_addr  (addr_i),
    .user_wdata (wdata_i),
    .user_be    (be_i),
    .ready      (ready_o),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be)
  );

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  logic              v1, e1, werr;
  logic [DATA_W-1:0] d1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1   <= 1'b0;
      e1   <= 1'b0;
      d1   <= '0;
      werr <= 1'b0;
    end else begin
      v1   <= rd_acc;
      e1   <= rd_acc & ~in_range;
      werr <= wr_err;
      if (rd_acc) d1 <= in_range ? mem[addr_i] : '0;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              v2, e2;
    logic [DATA_W-1:0] d2;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        v2 <= 1'b0;
        e2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        e2 <= e1;
        if (v1) d2 <= d1;
      end
    end

    assign rvalid_o = v2;
    assign rdata_o  = d2;
    assign err_o    = e2 | werr;
  end else begin : g_lat1
    assign rvalid_o = v1;
    assign rdata_o  = d1;
    assign err_o    = e1 | werr;
  end

endmodule
